// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-stage stall masks, exception flush/redirect,
// stall watchdog and a saturating stalled-cycle counter.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_BASE = 32'h0000_0020,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  input  logic        timeout_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  localparam int unsigned WD_W = 16;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(TIMEOUT - 1);
  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e          state;
  state_e          state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            stalled;
  logic            wd_trip;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // Next state: a flush cycle always returns to RUN
  always_comb begin
    state_nxt = ST_RUN;
    case (state)
      ST_RUN, ST_STALL: begin
        if (excepttype != 32'h0) state_nxt = ST_FLUSH;
        else if (stalled)        state_nxt = ST_STALL;
        else                     state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs: exception outranks all stall requests; everything quiet in reset or FLUSH
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst && state != ST_FLUSH) begin
      if (excepttype != 32'h0) begin
        flush  = 1'b1;
        new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_BASE;
      end else if (stallreq_mem) begin
        stall = 6'b011111;
      end else if (stallreq_ex) begin
        stall = 6'b001111;
      end else if (stallreq_id) begin
        stall = 6'b000111;
      end
    end
  end

  assign stalled = |stall;
  assign wd_trip = stalled && (wd_cnt == WD_TRIP);

  // Watchdog counts consecutive stalled cycles and parks at TIMEOUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   wd_cnt <= '0;
    else if (!stalled)          wd_cnt <= '0;
    else if (wd_cnt != WD_MAX)  wd_cnt <= wd_cnt + WD_W'(1);
  end

  // Sticky timeout flag; a coincident set beats the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             stall_timeout <= 1'b0;
    else if (wd_trip)     stall_timeout <= 1'b1;
    else if (timeout_clr) stall_timeout <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      stall_cycles <= 32'h0;
    else if (stalled && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter EXC_BASE, default 32'h0000_0020, exception handler entry address.
REQ-002 Parameter TIMEOUT, default 255, consecutive stalled cycles before watchdog trips (range 1..65535).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 stallreq_id  in  1  ID-stage stall request (load-use hazard).
REQ-006 stallreq_ex  in  1  EX-stage stall request (multi-cycle mul/div).
REQ-007 stallreq_mem  in  1  MEM-stage stall request (bus wait).
REQ-008 excepttype  in  32  exception code from MEM stage; 0 = none.
REQ-009 cp0_epc  in  32  current EPC from CP0.
REQ-010 timeout_clr  in  1  clears sticky watchdog flag.
REQ-011 stall  out  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-012 flush  out  1  flush all pipeline registers this cycle.
REQ-013 new_pc  out  32  redirect target, valid only when flush=1.
REQ-014 stall_timeout  out  1  sticky watchdog flag.
REQ-015 stall_cycles  out  32  saturating count of stalled cycles.

Function
REQ-016 State register holds one of RUN, STALL, FLUSH.
REQ-017 stall, flush, new_pc are combinational from current state and current inputs (same-cycle response, zero latency).
REQ-018 In RUN or STALL with excepttype != 0: flush=1, stall=6'b000000, next state FLUSH; exception outranks every stall request.
REQ-019 new_pc = cp0_epc when excepttype = 32'h0000_000e (eret); otherwise new_pc = EXC_BASE.
REQ-020 Codes 32'h1 (interrupt), 32'h8 (syscall), 32'ha (invalid inst), 32'hd (trap), 32'hc (overflow) and any other nonzero value are treated as exceptions to EXC_BASE.
REQ-021 In RUN or STALL with no exception, stall priority is mem > ex > id: mem -> 6'b011111, else ex -> 6'b001111, else id -> 6'b000111, else 6'b000000; flush=0.
REQ-022 In RUN or STALL with no exception, next state is STALL when stall != 0, else RUN.
REQ-023 FLUSH lasts exactly one cycle: stall=0, flush=0, new_pc=0; excepttype and all stall requests are ignored; next state RUN unconditionally.
REQ-024 new_pc = 32'h0 whenever flush=0.
REQ-025 Watchdog counter (16 bits) increments each cycle stall != 0 and clears to 0 on any cycle stall == 0 or flush = 1.
REQ-026 stall_timeout sets on the rising edge at which the watchdog counter equals TIMEOUT-1 while stall != 0, i.e. it is visible after TIMEOUT consecutive stalled cycles; the counter then holds at TIMEOUT.
REQ-027 stall_timeout remains set until timeout_clr=1 at a rising edge; if timeout_clr and a set condition coincide, set wins.
REQ-028 stall_cycles increments by 1 on each rising edge where stall != 0, saturating at 32'hFFFF_FFFF (no wrap).
REQ-029 The block never drives flush=1 and stall != 0 in the same cycle.

Reset
REQ-030 While rst=0: state = RUN, watchdog counter = 0, stall_timeout = 0, stall_cycles = 0; stall = 0, flush = 0, new_pc = 0 regardless of other inputs.
REQ-031 Reset assertion mid-STALL or mid-FLUSH takes effect immediately (asynchronously); after release the first edge evaluates from RUN.

Verification
REQ-032 Only stallreq_id=1 for 3 cycles -> stall=6'b000111 for those 3 cycles, stall_cycles=3, state returns to RUN.
REQ-033 stallreq_id, stallreq_ex, stallreq_mem all 1 -> stall=6'b011111; drop mem -> 6'b001111; drop ex -> 6'b000111.
REQ-034 excepttype=32'h8 with stallreq_mem=1 -> same cycle flush=1, stall=0, new_pc=32'h20; next cycle flush=0 even with excepttype=32'hc still present.
REQ-035 excepttype=32'he, cp0_epc=32'h0000_1234 -> flush=1, new_pc=32'h0000_1234 for one cycle.
REQ-036 TIMEOUT=4, stallreq_ex held 4 cycles -> stall_timeout=1 after 4th edge and stays 1 after request drops; timeout_clr pulse -> 0.
REQ-037 rst=0 asserted during a stall with stall_cycles=5 -> all outputs and counters 0 immediately; after release, stallreq_id=1 -> stall=6'b000111, stall_cycles=1 after one edge.
